// File: rtl/rf_pulse_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pulse_scheduler
//  Description : Drives the single RF-switch line for two requesters: the
//                Mach-Zehnder sequence (pi/2 - T - pi - T - pi/2) and a Rabi
//                scan whose pulse length steps up after each run. Trigger
//                pins are asynchronous; they are synchronised, edge-detected,
//                and held in a one-deep pending flag per requester until
//                granted. MZ has priority when both are pending in IDLE.
//  Ports       : clk          system clock
//                rst_n        asynchronous active-low reset
//                mz_trig      MZ request level (async), rising edge = request
//                rabi_trig    Rabi request level (async), rising edge = request
//                rabi_reset   synchronous; restart the scan at RABI_START
//                rf           registered RF switch drive
//                busy         sequencer not idle
//                active_mz    MZ sequence in progress
//                active_rabi  Rabi run in progress
//                seq_done     one-cycle pulse after the hold-off ends
//                rabi_len     length the next Rabi run will use
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_pulse_scheduler #(
    parameter int unsigned CW         = 32,
    parameter int unsigned DEAD       = 400,
    parameter int unsigned PI_2       = 333,
    parameter int unsigned PI         = 666,
    parameter int unsigned T_WAIT     = 66600,
    parameter int unsigned HOLDOFF    = 33300,
    parameter int unsigned RABI_START = 66,
    parameter int unsigned RABI_STEP  = 66,
    parameter int unsigned RABI_MAX   = 6600
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mz_trig,
    input  logic          rabi_trig,
    input  logic          rabi_reset,
    output logic          rf,
    output logic          busy,
    output logic          active_mz,
    output logic          active_rabi,
    output logic          seq_done,
    output logic [CW-1:0] rabi_len
);

    localparam logic [3:0] c_IDLE  = 4'd0;
    localparam logic [3:0] c_DEAD  = 4'd1;
    localparam logic [3:0] c_MZ_P1 = 4'd2;
    localparam logic [3:0] c_MZ_W1 = 4'd3;
    localparam logic [3:0] c_MZ_P2 = 4'd4;
    localparam logic [3:0] c_MZ_W2 = 4'd5;
    localparam logic [3:0] c_MZ_P3 = 4'd6;
    localparam logic [3:0] c_RB_P  = 4'd7;
    localparam logic [3:0] c_HOLD  = 4'd8;

    localparam logic [CW-1:0] c_DEAD_N    = CW'(DEAD);
    localparam logic [CW-1:0] c_PI_2_N    = CW'(PI_2);
    localparam logic [CW-1:0] c_PI_N      = CW'(PI);
    localparam logic [CW-1:0] c_T_WAIT_N  = CW'(T_WAIT);
    localparam logic [CW-1:0] c_HOLDOFF_N = CW'(HOLDOFF);
    localparam logic [CW-1:0] c_RB_START  = CW'(RABI_START);
    localparam logic [CW:0]   c_RB_STEP   = (CW+1)'(RABI_STEP);
    localparam logic [CW:0]   c_RB_MAX    = (CW+1)'(RABI_MAX);

    // ------------------------------------------------------------------
    // Trigger synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [1:0] r_mz_sync;
    logic [1:0] r_rabi_sync;
    logic       r_mz_hist;
    logic       r_rabi_hist;
    logic [1:0] r_warm;
    logic       w_mz_edge;
    logic       w_rabi_edge;

    // The history flops keep their reset value of 1 until the synchroniser
    // stages hold real samples. Otherwise a level already high at reset
    // release would look like a rising edge once it reaches sync stage 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mz_sync   <= 2'b00;
            r_rabi_sync <= 2'b00;
            r_mz_hist   <= 1'b1;
            r_rabi_hist <= 1'b1;
            r_warm      <= 2'b00;
        end else begin
            r_mz_sync   <= {r_mz_sync[0], mz_trig};
            r_rabi_sync <= {r_rabi_sync[0], rabi_trig};
            r_warm      <= {r_warm[0], 1'b1};
            if (r_warm[1]) begin
                r_mz_hist   <= r_mz_sync[1];
                r_rabi_hist <= r_rabi_sync[1];
            end
        end
    end

    assign w_mz_edge   = r_mz_sync[1] & ~r_mz_hist;
    assign w_rabi_edge = r_rabi_sync[1] & ~r_rabi_hist;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    logic [3:0]    r_state;
    logic [3:0]    w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_dur;
    logic          w_last;
    logic          r_mz_pend;
    logic          r_rabi_pend;
    logic          r_seq_mz;
    logic [CW-1:0] r_run_len;
    logic [CW-1:0] r_rabi_len;
    logic          r_rst_pend;
    logic          w_grant_mz;
    logic          w_grant_rabi;
    logic          w_rb_done;
    logic          w_defer_rst;
    logic [CW:0]   w_sum;
    logic [CW-1:0] w_next_len;
    logic          r_rf;
    logic          r_seq_done;

    always_comb begin
        w_dur = CW'(1);
        case (r_state)
            c_DEAD:  w_dur = c_DEAD_N;
            c_MZ_P1: w_dur = c_PI_2_N;
            c_MZ_W1: w_dur = c_T_WAIT_N;
            c_MZ_P2: w_dur = c_PI_N;
            c_MZ_W2: w_dur = c_T_WAIT_N;
            c_MZ_P3: w_dur = c_PI_2_N;
            c_RB_P:  w_dur = r_run_len;
            c_HOLD:  w_dur = c_HOLDOFF_N;
            default: w_dur = CW'(1);
        endcase
    end

    assign w_last = (r_cnt == (w_dur - CW'(1)));

    always_comb begin
        w_next       = r_state;
        w_grant_mz   = 1'b0;
        w_grant_rabi = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (r_mz_pend) begin
                    w_grant_mz = 1'b1;
                    w_next     = c_DEAD;
                end else if (r_rabi_pend) begin
                    w_grant_rabi = 1'b1;
                    w_next       = c_DEAD;
                end
            end
            c_DEAD:  if (w_last) w_next = r_seq_mz ? c_MZ_P1 : c_RB_P;
            c_MZ_P1: if (w_last) w_next = c_MZ_W1;
            c_MZ_W1: if (w_last) w_next = c_MZ_P2;
            c_MZ_P2: if (w_last) w_next = c_MZ_W2;
            c_MZ_W2: if (w_last) w_next = c_MZ_P3;
            c_MZ_P3: if (w_last) w_next = c_HOLD;
            c_RB_P:  if (w_last) w_next = c_HOLD;
            c_HOLD:  if (w_last) w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Rabi length bookkeeping. The sum is one bit wider so a large step
    // cannot wrap around and slip under RABI_MAX.
    assign w_rb_done   = (r_state == c_RB_P) && w_last;
    assign w_sum       = {1'b0, r_rabi_len} + c_RB_STEP;
    assign w_next_len  = (w_sum > c_RB_MAX) ? c_RB_START : w_sum[CW-1:0];
    // A scan restart requested once a Rabi run is committed (grant cycle,
    // dead time or pulse) is applied at completion instead of the step.
    assign w_defer_rst = w_grant_rabi ||
                         (!r_seq_mz && ((r_state == c_DEAD) || (r_state == c_RB_P)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_mz_pend   <= 1'b0;
            r_rabi_pend <= 1'b0;
            r_seq_mz    <= 1'b0;
            r_run_len   <= c_RB_START;
            r_rabi_len  <= c_RB_START;
            r_rst_pend  <= 1'b0;
            r_rf        <= 1'b0;
            r_seq_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state || r_state == c_IDLE) ? '0 : r_cnt + CW'(1);

            // A new edge outranks the grant clear so a request arriving on
            // the grant cycle is still remembered.
            r_mz_pend   <= (r_mz_pend & ~w_grant_mz) | w_mz_edge;
            r_rabi_pend <= (r_rabi_pend & ~w_grant_rabi) | w_rabi_edge;

            if (w_grant_mz || w_grant_rabi) begin
                r_seq_mz <= w_grant_mz;
            end
            if (w_grant_rabi) begin
                r_run_len <= r_rabi_len;
            end

            if (w_rb_done) begin
                r_rabi_len <= (r_rst_pend || rabi_reset) ? c_RB_START : w_next_len;
                r_rst_pend <= 1'b0;
            end else if (rabi_reset) begin
                if (w_defer_rst) begin
                    r_rst_pend <= 1'b1;
                end else begin
                    r_rabi_len <= c_RB_START;
                end
            end

            r_rf       <= (w_next == c_MZ_P1) || (w_next == c_MZ_P2) ||
                          (w_next == c_MZ_P3) || (w_next == c_RB_P);
            r_seq_done <= (r_state == c_HOLD) && (w_next == c_IDLE);
        end
    end

    assign rf          = r_rf;
    assign busy        = (r_state != c_IDLE);
    assign active_mz   = busy &  r_seq_mz;
    assign active_rabi = busy & ~r_seq_mz;
    assign seq_done    = r_seq_done;
    assign rabi_len    = r_rabi_len;

endmodule
`default_nettype wire

// File: tb/tb_rf_pulse_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_pulse_scheduler
//  Description : Directed self-checking bench for rf_pulse_scheduler with
//                small timing parameters (DEAD=4, PI_2=3, PI=6, T_WAIT=10,
//                HOLDOFF=5, RABI 2/2/6). Each sequence is captured as a list
//                of rf run lengths and compared to hand-computed patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_pulse_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mz_trig;
    logic        rabi_trig;
    logic        rabi_reset;
    logic        rf;
    logic        busy;
    logic        active_mz;
    logic        active_rabi;
    logic        seq_done;
    logic [31:0] rabi_len;

    int n_pass  = 0;
    int n_total = 0;

    // capture results
    int   runs[$];
    logic run_first;
    int   nbusy;
    int   sd_in_run;
    logic am;
    logic ar;
    logic sd_end;

    localparam string c_MZ_PAT = "0:4,3,10,6,10,3,5";

    rf_pulse_scheduler #(
        .CW(32), .DEAD(4), .PI_2(3), .PI(6), .T_WAIT(10), .HOLDOFF(5),
        .RABI_START(2), .RABI_STEP(2), .RABI_MAX(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mz_trig(mz_trig), .rabi_trig(rabi_trig),
        .rabi_reset(rabi_reset), .rf(rf), .busy(busy), .active_mz(active_mz),
        .active_rabi(active_rabi), .seq_done(seq_done), .rabi_len(rabi_len)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Wait (at negedges) until busy is seen, returning how many edges it took.
    task automatic wait_busy(input int bound, output int lat);
        lat = 0;
        while (busy !== 1'b1 && lat < bound) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Record rf run lengths for every busy cycle; ends on the first idle sample.
    task automatic capture();
        int   cur;
        logic prev;
        runs.delete();
        nbusy = 0; sd_in_run = 0; am = 1'b0; ar = 1'b0;
        prev = rf; run_first = rf; cur = 0;
        while (busy === 1'b1 && nbusy < 1000) begin
            if (rf !== prev) begin
                runs.push_back(cur);
                cur  = 0;
                prev = rf;
            end
            cur++;
            nbusy++;
            if (seq_done === 1'b1) sd_in_run++;
            if (active_mz === 1'b1) am = 1'b1;
            if (active_rabi === 1'b1) ar = 1'b1;
            @(negedge clk);
        end
        runs.push_back(cur);
        sd_end = seq_done;
    endtask

    function automatic string fmt_runs();
        string s;
        s = $sformatf("%0d:", run_first);
        foreach (runs[i]) begin
            if (i != 0) s = {s, ","};
            s = {s, $sformatf("%0d", runs[i])};
        end
        return s;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; mz_trig = 1'b0; rabi_trig = 1'b0; rabi_reset = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (rf !== 1'b0) $display("FAIL reset_rf got %b want 0", rf); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_total++; if (seq_done !== 1'b0) $display("FAIL reset_seq_done got %b want 0", seq_done); else n_pass++;
        n_total++; if ({active_mz, active_rabi} !== 2'b00)
            $display("FAIL reset_active got %b want 00", {active_mz, active_rabi}); else n_pass++;
        n_total++; if (rabi_len !== 32'd2) $display("FAIL reset_rabi_len got %0d want 2", rabi_len); else n_pass++;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_mz_single();
        int lat;
        mz_trig = 1'b1;
        wait_busy(10, lat);
        n_total++; if (lat !== 4) $display("FAIL mz_latency got %0d want 4", lat); else n_pass++;
        n_total++; if ({active_mz, active_rabi} !== 2'b10)
            $display("FAIL mz_active got %b want 10", {active_mz, active_rabi}); else n_pass++;
        capture();
        mz_trig = 1'b0;
        n_total++; if (fmt_runs() != c_MZ_PAT) $display("FAIL mz_pattern got %s want %s", fmt_runs(), c_MZ_PAT); else n_pass++;
        n_total++; if (nbusy !== 41) $display("FAIL mz_busy_len got %0d want 41", nbusy); else n_pass++;
        n_total++; if (sd_in_run !== 0 || sd_end !== 1'b1)
            $display("FAIL mz_seq_done got in_run=%0d end=%b want 0/1", sd_in_run, sd_end); else n_pass++;
        @(negedge clk);
        n_total++; if (seq_done !== 1'b0) $display("FAIL mz_seq_done_width got %b want 0", seq_done); else n_pass++;
        n_total++; if (rabi_len !== 32'd2) $display("FAIL mz_rabi_len got %0d want 2", rabi_len); else n_pass++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_rabi_scan();
        int widths[4] = '{2, 4, 6, 2};
        int lens[4]   = '{4, 6, 2, 4};
        int lat;
        string exp;
        for (int r = 0; r < 4; r++) begin
            rabi_trig = 1'b1;
            wait_busy(10, lat);
            n_total++; if (lat !== 4) $display("FAIL rabi_latency[%0d] got %0d want 4", r, lat); else n_pass++;
            capture();
            rabi_trig = 1'b0;
            exp = $sformatf("0:4,%0d,5", widths[r]);
            n_total++; if (fmt_runs() != exp) $display("FAIL rabi_pattern[%0d] got %s want %s", r, fmt_runs(), exp); else n_pass++;
            n_total++; if (nbusy !== 9 + widths[r]) $display("FAIL rabi_busy_len[%0d] got %0d want %0d", r, nbusy, 9 + widths[r]); else n_pass++;
            n_total++; if ({am, ar} !== 2'b01) $display("FAIL rabi_active[%0d] got %b want 01", r, {am, ar}); else n_pass++;
            n_total++; if (rabi_len !== 32'(lens[r])) $display("FAIL rabi_len[%0d] got %0d want %0d", r, rabi_len, lens[r]); else n_pass++;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_rabi_reset_idle();
        rabi_reset = 1'b1;
        @(negedge clk);
        rabi_reset = 1'b0;
        n_total++; if (rabi_len !== 32'd2) $display("FAIL rabi_reset_idle got %0d want 2", rabi_len); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int lat;
        int extra;
        mz_trig = 1'b1; rabi_trig = 1'b1;
        wait_busy(10, lat);
        n_total++; if (lat !== 4) $display("FAIL sim_latency got %0d want 4", lat); else n_pass++;
        capture();
        mz_trig = 1'b0; rabi_trig = 1'b0;
        n_total++; if (am !== 1'b1 || fmt_runs() != c_MZ_PAT)
            $display("FAIL sim_first_mz got am=%b %s want 1 %s", am, fmt_runs(), c_MZ_PAT); else n_pass++;
        wait_busy(10, lat);
        n_total++; if (lat !== 1) $display("FAIL sim_idle_gap got %0d want 1", lat); else n_pass++;
        capture();
        n_total++; if ({am, ar} !== 2'b01 || fmt_runs() != "0:4,2,5")
            $display("FAIL sim_second_rabi got %b %s want 01 0:4,2,5", {am, ar}, fmt_runs()); else n_pass++;
        n_total++; if (rabi_len !== 32'd4) $display("FAIL sim_rabi_len got %0d want 4", rabi_len); else n_pass++;
        extra = 0;
        repeat (10) begin @(negedge clk); if (busy === 1'b1) extra++; end
        n_total++; if (extra !== 0) $display("FAIL sim_no_extra got %0d busy cycles want 0", extra); else n_pass++;
    endtask

    // Two more MZ edges during the MZ run: the first latches, the second is
    // dropped. MZ wins arbitration, so the repeat MZ runs ahead of the Rabi.
    task automatic test_repeated();
        int lat;
        int extra;
        mz_trig = 1'b1; rabi_trig = 1'b1;
        wait_busy(10, lat);
        n_total++; if (lat !== 4) $display("FAIL rep_latency got %0d want 4", lat); else n_pass++;
        fork
            capture();
            begin
                repeat (3) @(negedge clk); mz_trig = 1'b0;
                repeat (3) @(negedge clk); mz_trig = 1'b1;
                repeat (3) @(negedge clk); mz_trig = 1'b0;
                repeat (3) @(negedge clk); mz_trig = 1'b1;
                repeat (3) @(negedge clk); mz_trig = 1'b0; rabi_trig = 1'b0;
            end
        join
        n_total++; if (am !== 1'b1 || fmt_runs() != c_MZ_PAT)
            $display("FAIL rep_first got am=%b %s want 1 %s", am, fmt_runs(), c_MZ_PAT); else n_pass++;
        wait_busy(10, lat);
        n_total++; if (lat !== 1) $display("FAIL rep_gap1 got %0d want 1", lat); else n_pass++;
        capture();
        n_total++; if ({am, ar} !== 2'b10 || fmt_runs() != c_MZ_PAT)
            $display("FAIL rep_second_mz got %b %s want 10 %s", {am, ar}, fmt_runs(), c_MZ_PAT); else n_pass++;
        wait_busy(10, lat);
        n_total++; if (lat !== 1) $display("FAIL rep_gap2 got %0d want 1", lat); else n_pass++;
        capture();
        n_total++; if ({am, ar} !== 2'b01 || fmt_runs() != "0:4,4,5")
            $display("FAIL rep_third_rabi got %b %s want 01 0:4,4,5", {am, ar}, fmt_runs()); else n_pass++;
        n_total++; if (rabi_len !== 32'd6) $display("FAIL rep_rabi_len got %0d want 6", rabi_len); else n_pass++;
        extra = 0;
        repeat (60) begin @(negedge clk); if (busy === 1'b1) extra++; end
        n_total++; if (extra !== 0) $display("FAIL rep_dropped_edge got %0d busy cycles want 0", extra); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat;
        int extra;
        mz_trig = 1'b1;
        wait_busy(10, lat);
        n_total++; if (lat !== 4) $display("FAIL mid_latency got %0d want 4", lat); else n_pass++;
        repeat (19) @(negedge clk);
        n_total++; if (rf !== 1'b1) $display("FAIL mid_in_p2 got rf=%b want 1", rf); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (rf !== 1'b0 || busy !== 1'b0)
            $display("FAIL mid_abort got rf=%b busy=%b want 0/0", rf, busy); else n_pass++;
        n_total++; if (rabi_len !== 32'd2) $display("FAIL mid_rabi_len got %0d want 2", rabi_len); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (12) begin @(negedge clk); if (busy === 1'b1) extra++; end
        n_total++; if (extra !== 0) $display("FAIL mid_held_level got %0d busy cycles want 0", extra); else n_pass++;
        mz_trig = 1'b0;
        repeat (3) @(negedge clk);
        mz_trig = 1'b1;
        wait_busy(10, lat);
        n_total++; if (lat !== 4) $display("FAIL mid_retrig_latency got %0d want 4", lat); else n_pass++;
        capture();
        mz_trig = 1'b0;
        n_total++; if (fmt_runs() != c_MZ_PAT || nbusy !== 41)
            $display("FAIL mid_retrig got %s/%0d want %s/41", fmt_runs(), nbusy, c_MZ_PAT); else n_pass++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_rabi_reset_run();
        int lat;
        logic [31:0] mid_len;
        // bring the scan to length 4
        rabi_trig = 1'b1;
        wait_busy(10, lat);
        capture();
        rabi_trig = 1'b0;
        n_total++; if (fmt_runs() != "0:4,2,5" || rabi_len !== 32'd4)
            $display("FAIL rr_setup got %s len=%0d want 0:4,2,5 len=4", fmt_runs(), rabi_len); else n_pass++;
        repeat (3) @(negedge clk);
        // restart requested mid-pulse
        rabi_trig = 1'b1;
        wait_busy(10, lat);
        fork
            capture();
            begin
                repeat (5) @(negedge clk); rabi_reset = 1'b1;
                @(negedge clk); rabi_reset = 1'b0;
                mid_len = rabi_len;
                n_total++; if (mid_len !== 32'd4) $display("FAIL rr_len_during_run got %0d want 4", mid_len); else n_pass++;
            end
        join
        rabi_trig = 1'b0;
        n_total++; if (fmt_runs() != "0:4,4,5") $display("FAIL rr_pulse got %s want 0:4,4,5", fmt_runs()); else n_pass++;
        n_total++; if (rabi_len !== 32'd2) $display("FAIL rr_len_after got %0d want 2", rabi_len); else n_pass++;
        repeat (3) @(negedge clk);
        rabi_trig = 1'b1;
        wait_busy(10, lat);
        capture();
        rabi_trig = 1'b0;
        n_total++; if (fmt_runs() != "0:4,2,5" || rabi_len !== 32'd4)
            $display("FAIL rr_next_run got %s len=%0d want 0:4,2,5 len=4", fmt_runs(), rabi_len); else n_pass++;
        repeat (3) @(negedge clk);
        // restart on the grant cycle itself
        rabi_trig = 1'b1;
        repeat (3) @(negedge clk);
        rabi_reset = 1'b1;
        @(negedge clk);
        rabi_reset = 1'b0;
        n_total++; if (busy !== 1'b1) $display("FAIL rr_grant_busy got %b want 1", busy); else n_pass++;
        capture();
        rabi_trig = 1'b0;
        n_total++; if (fmt_runs() != "0:4,4,5" || rabi_len !== 32'd2)
            $display("FAIL rr_grant_cycle got %s len=%0d want 0:4,4,5 len=2", fmt_runs(), rabi_len); else n_pass++;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mz_single();
        test_rabi_scan();
        test_rabi_reset_idle();
        test_simultaneous();
        test_repeated();
        test_reset_mid();
        test_rabi_reset_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
